// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling ratio, baud divisor
// and the majority-of-3 vote, kept here so a future transmitter can reuse them.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRKWAIT
  } rx_state_t;

  localparam int OVS = 16;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (OVS * baud);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pop_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1-style UART receiver with 16x oversampling, mid-bit majority voting,
// framing/overrun reporting and a FWFT receive FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_50,
  input  logic                          CPU_RESET,
  input  logic                          RXD,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_t            state;
  logic                 rxd_meta;
  logic                 rxd_s;
  logic [PW-1:0]        presc;
  logic [3:0]           samp;
  logic [2:0]           bit_idx;
  logic                 v7;
  logic                 v8;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;
  logic                 mid;
  logic                 vote;
  logic                 push;
  logic                 full;

  always_ff @(posedge CLK_50 or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_s    <= rxd_meta;
    end
  end

  // The vote completes on the sample-9 tick, using samples 7 and 8 held from earlier ticks.
  assign tick = (presc == PW'(DIV - 1));
  assign mid  = tick && (samp == 4'd9);
  assign vote = maj3(v7, v8, rxd_s);
  assign push = (state == STOP) && mid && vote;
  assign busy = (state != IDLE);

  always_ff @(posedge CLK_50 or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      state     <= IDLE;
      presc     <= '0;
      samp      <= '0;
      bit_idx   <= '0;
      v7        <= 1'b0;
      v8        <= 1'b0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= push && full && !rx_ready;
      if (state == IDLE) begin
        presc <= '0;
        samp  <= '0;
        if (!rxd_s) state <= START;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          samp <= samp + 4'd1;
          if (samp == 4'd7) v7 <= rxd_s;
          if (samp == 4'd8) v8 <= rxd_s;
        end
        case (state)
          START: if (mid) begin
            bit_idx <= '0;
            state   <= vote ? IDLE : DATA;
          end
          DATA: if (mid) begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
          end
          STOP: if (mid) begin
            if (vote) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRKWAIT;
            end
          end
          BRKWAIT: if (rxd_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK_50),
    .rst_n     (CPU_RESET),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .valid     (rx_valid),
    .full      (full),
    .count     (fifo_count)
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Hand-written UART receiver that deserialises the asynchronous RXD line into bytes and buffers them in a small FIFO for local logic. It is the receiving end of the 8N1 serial links carried on RX0/RX1, and it lets fabric logic consume serial data directly, without the soft-CPU UART core. It uses 16x oversampling with mid-bit majority voting, and reports framing errors and FIFO overruns.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DATA_BITS, 8, data bits per frame (5..8), LSB first, no parity, 1 stop bit
FIFO_DEPTH, 16, receive FIFO entries (power of two, >= 2)

Ports:
CLK_50  input  1  system clock; all logic on rising edge
CPU_RESET  input  1  asynchronous, active-low reset
RXD  input  1  serial line, idle high, asynchronous to CLK_50
rx_data  output  DATA_BITS  FIFO head byte; valid only while rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts the head byte when rx_valid and rx_ready are both 1
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full
busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (CPU_RESET=0, asynchronous):
  - Synchroniser flops load 1.
  - FSM goes to IDLE.
  - Prescaler and bit counters go to 0.
  - FIFO is emptied.
  - rx_valid=0, fifo_count=0, frame_err=0, overrun=0, busy=0, rx_data=0.
- Reset mid-frame aborts the frame with no FIFO write and no pulse.
- Synchronisation: RXD passes through 2 flops (rxd_s). All decisions use rxd_s, so the line has 2 cycles of latency.
- Oversample tick:
  - DIV = CLK_HZ/(16*BAUD), integer division. Default is 27.
  - The prescaler counts 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - The prescaler and the sample counter (0..15) are cleared on the start-edge detection cycle.
- FSM:
  - IDLE: rxd_s=0 -> START.
  - START: takes a majority of samples 7,8,9 of the bit. Result 0 -> DATA with bit index 0. Result 1 -> IDLE (glitch rejected, no flag).
  - DATA: a majority vote at samples 7/8/9 of each bit is shifted in LSB first. After DATA_BITS bits -> STOP.
  - STOP: majority vote at samples 7/8/9.
    - Vote 1: push the byte, then go to IDLE.
    - Vote 0: frame_err pulse, byte discarded, then go to BRKWAIT.
  - BRKWAIT: stays until rxd_s=1, then goes to IDLE. This prevents a break condition from re-triggering start.
- IDLE is re-entered at the stop-bit mid-sample, so back-to-back frames need no extra idle time.
- FIFO: first-word-fall-through.
  - rx_data/rx_valid reflect the head combinationally from registered storage.
  - A push becomes visible on rx_valid the cycle after the stop-bit decision.
- Simultaneous events:
  - Push and pop in the same cycle: fifo_count is unchanged, and the push is accepted even when full.
  - Push while full with no pop: byte dropped, overrun pulses for 1 cycle, FIFO contents unchanged.
  - Pop while empty: ignored.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count.

Decomposition:
- Shared uart package/include holds:
  - FSM state encodings: IDLE, START, DATA, STOP, BRKWAIT.
  - OVS=16 constant.
  - The DIV computation and the majority-of-3 function, so a future uart_tx reuses them.
- One sub-module: sync_fifo (parameterised width/depth, FWFT, count output). The FSM, prescaler and synchroniser stay in uart_rx_fifo.

Test Plan:
- Sim with CLK_HZ=640000, BAUD=10000 (DIV=4, 64 cycles/bit). Send 0xA5 8N1, rx_ready=0 -> rx_valid rises, rx_data=0xA5, fifo_count=1, no flags.
- 2-cycle low glitch on idle RXD -> FSM returns to IDLE, fifo_count=0, busy falls within one bit time, no flags.
- Send 0x3C with stop bit forced low, then hold RXD low 3 bit times -> one frame_err pulse, no push, busy stays high until RXD=1.
- Send 17 bytes 0x00..0x10 with rx_ready=0 -> fifo_count=16, a single overrun pulse on the 17th, head=0x00. Then pop all -> 0x00..0x0F in order.
- FIFO full, rx_ready=1 held as a byte completes -> count stays 16, no overrun, last entry = new byte.
- Assert CPU_RESET=0 mid DATA bit 4 of a frame -> all outputs 0. After release, the next clean frame 0x5A is received correctly.
